// File: rtl/door_pkg.sv
// door_pkg: shared state codes, state width and default timing for the door channel
package door_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_CLOSED    = 3'd0,
    S_OPENING   = 3'd1,
    S_OPEN_HOLD = 3'd2,
    S_CLOSING   = 3'd3,
    S_DEAD      = 3'd4,
    S_ESTOP     = 3'd5,
    S_FAULT     = 3'd6
  } state_e;
  localparam int HOLD_CYCLES_DEF   = 16;
  localparam int TRAVEL_CYCLES_DEF = 64;
  localparam int DEAD_CYCLES_DEF   = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/door_timer.sv
// door_timer: clear/enable saturating up-counter with a terminal-count compare
// Ports: clk, rst_n (sync, active-low), clr_i (restart at 0), en_i (count),
//        tc_i (terminal count), hit_o (counter equals tc_i this cycle)
module door_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign hit_o = cnt_q == tc_i;
endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: timed open/close sequencer with hold, reversal dead-time, travel timeout and sticky fault
// Ports: clk, rst_n (sync, active-low); sen presence, se e-stop, la/lc open/closed limits;
//        ma/mc motor commands, state code, fault flag (all registered)
module door_sequencer
  import door_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DEAD_CYCLES   = DEAD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sen,
  input  logic               se,
  input  logic               la,
  input  logic               lc,
  output logic               ma,
  output logic               mc,
  output logic [STATE_W-1:0] state,
  output logic               fault
);
  localparam int CW = cnt_width(HOLD_CYCLES, TRAVEL_CYCLES, DEAD_CYCLES);
  state_e state_q, state_d;
  logic ma_q, ma_d, mc_q, mc_d, fault_q, fault_d;
  logic hit, clr, en, fault_st;
  logic [CW-1:0] tc;
  // one counter serves every timed state; the compare value follows the state
  always_comb begin
    tc  = (state_q == S_OPEN_HOLD) ? CW'(HOLD_CYCLES - 1) :
          (state_q == S_DEAD)      ? CW'(DEAD_CYCLES - 1) : CW'(TRAVEL_CYCLES - 1);
    en  = state_q inside {S_OPENING, S_OPEN_HOLD, S_CLOSING, S_DEAD};
    clr = (state_d != state_q) || (state_q == S_OPEN_HOLD && sen);
  end
  door_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (en),
    .tc_i  (tc),
    .hit_o (hit)
  );
  // the unused code 7 behaves as FAULT
  assign fault_st = state_q >= S_FAULT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLOSED;
      ma_q    <= 1'b0;
      mc_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mc_q    <= mc_d;
      fault_q <= fault_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (la && lc) state_d = S_FAULT;
    else if (fault_st) state_d = S_FAULT;
    else if (se) state_d = S_ESTOP;
    else begin
      case (state_q)
        S_CLOSED:    state_d = !sen ? S_CLOSED : la ? S_OPEN_HOLD : S_OPENING;
        S_OPENING:   state_d = la ? S_OPEN_HOLD : hit ? S_FAULT : S_OPENING;
        S_OPEN_HOLD: state_d = (!sen && hit) ? S_CLOSING : S_OPEN_HOLD;
        S_CLOSING:   state_d = lc ? S_CLOSED : sen ? S_DEAD : hit ? S_FAULT : S_CLOSING;
        S_DEAD:      state_d = hit ? S_OPENING : S_DEAD;
        S_ESTOP:     state_d = (lc && !sen) ? S_CLOSED : la ? S_OPEN_HOLD : S_DEAD;
        default:     state_d = S_FAULT;
      endcase
    end
  end
  always_comb begin
    ma_d    = state_d == S_OPENING;
    mc_d    = state_d == S_CLOSING;
    fault_d = state_d == S_FAULT;
  end
  assign ma    = ma_q;
  assign mc    = mc_q;
  assign fault = fault_q;
  assign state = state_q;
endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer: scoreboard bench for door_sequencer against a cycle-level behavioural model
module tb_door_sequencer;
  localparam int H = 8, T = 20, D = 3;
  localparam int CLOSED = 0, OPENING = 1, HOLD = 2, CLOSING = 3, DEAD = 4, ESTOP = 5, FLT = 6;
  logic clk = 0, rst_n = 0, sen = 0, se = 0, la = 0, lc = 0;
  logic ma, mc, fault;
  logic [2:0] state;
  door_sequencer #(.HOLD_CYCLES(H), .TRAVEL_CYCLES(T), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sen(sen), .se(se), .la(la), .lc(lc),
    .ma(ma), .mc(mc), .state(state), .fault(fault)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] st; logic ma; logic mc; logic fault;} exp_t;
  exp_t q[$];
  exp_t got, want;
  int compared = 0, mismatched = 0, cyc_n = 0;
  int m_state = CLOSED;
  int m_age = 0;
  // model: m_age is how many cycles the door has already spent in the current
  // state (for the hold, how long the sensor has been quiet)
  task automatic drive(input bit r, input bit s, input bit e, input bit a, input bit c);
    int nxt;
    rst_n = r; sen = s; se = e; la = a; lc = c;
    if (!r) nxt = CLOSED;
    else if (a && c) nxt = FLT;
    else if (m_state == FLT) nxt = FLT;
    else if (e) nxt = ESTOP;
    else begin
      nxt = m_state;
      if (m_state == CLOSED && s) nxt = a ? HOLD : OPENING;
      if (m_state == OPENING) nxt = a ? HOLD : (m_age + 1 >= T) ? FLT : OPENING;
      if (m_state == HOLD && !s && m_age + 1 >= H) nxt = CLOSING;
      if (m_state == CLOSING) nxt = c ? CLOSED : s ? DEAD : (m_age + 1 >= T) ? FLT : CLOSING;
      if (m_state == DEAD && m_age + 1 >= D) nxt = OPENING;
      if (m_state == ESTOP) nxt = (c && !s) ? CLOSED : a ? HOLD : DEAD;
    end
    if (!r || nxt != m_state || (m_state == HOLD && s)) m_age = 0;
    else m_age = m_age + 1;
    m_state = nxt;
    q.push_back('{st: 3'(nxt), ma: nxt == OPENING, mc: nxt == CLOSING, fault: nxt == FLT});
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit a, input bit c);
    repeat (n) drive(1, 0, 0, a, c);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    cyc_n++;
    if (q.size() > 0) begin
      want = q.pop_front();
      got  = '{st: state, ma: ma, mc: mc, fault: fault};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got state=%0d ma=%b mc=%b fault=%b, want state=%0d ma=%b mc=%b fault=%b",
                 cyc_n, got.st, got.ma, got.mc, got.fault, want.st, want.ma, want.mc, want.fault);
      end
      compared++;
      if (ma && mc) begin
        mismatched++;
        $display("FAIL exclusive cycle %0d: got ma=%b mc=%b, want not both 1", cyc_n, ma, mc);
      end
    end
  end
  initial begin
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0); idle(9, 0, 0); drive(1, 0, 0, 1, 0);
    idle(8, 1, 0); idle(12, 0, 0); drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0); idle(4, 0, 0); drive(1, 0, 0, 1, 0); idle(2, 1, 0);
    repeat (5) drive(1, 1, 0, 1, 0);
    idle(9, 1, 0); idle(3, 0, 0); drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0); idle(2, 0, 0); drive(1, 0, 0, 1, 0); idle(8, 1, 0);
    idle(4, 0, 0); drive(1, 1, 0, 0, 0); idle(5, 0, 0);
    drive(1, 0, 0, 1, 0); idle(8, 1, 0); idle(2, 0, 0); drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0); idle(3, 0, 0);
    repeat (6) drive(1, 0, 1, 0, 0);
    idle(6, 0, 0); drive(1, 0, 0, 1, 0); idle(3, 1, 0); drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0); idle(22, 0, 0);
    repeat (8) drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1); idle(3, 0, 0); drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0); idle(2, 0, 0); drive(1, 0, 0, 1, 0); idle(8, 1, 0); idle(5, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0); idle(22, 0, 0); drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int lim;
      lim = ((i / 300) % 2) ? 9 : 39;
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, lim) == 0, $urandom_range(0, lim) == 0);
    end
    idle(2, 0, 0);
    @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/door_sequencer.md
# door_sequencer

Timed sequencer for the door-drive channel. It turns the presence sensor, the emergency stop and the open/closed limit switches into mutually exclusive open/close motor commands. It adds what the raw door decode lacks: a hold-open timer, obstruction reversal with motor dead-time, travel timeouts and a sticky fault. It sits between the `ui` input pins and the motor drivers on `uo`, and exports its state for the status pins.

## Interface
- `HOLD_CYCLES`, default 16: cycles the door stays open after presence clears.
- `TRAVEL_CYCLES`, default 64: maximum cycles in OPENING or CLOSING before FAULT.
- `DEAD_CYCLES`, default 4: motor-off cycles enforced before any direction change. Must be ≥1.
- `clk  in  1`: single system clock.
- `rst_n  in  1`: synchronous, active-low reset.
- `sen  in  1`: presence/obstruction sensor, 1 = object present.
- `se  in  1`: emergency stop, 1 = stop requested.
- `la  in  1`: open limit switch, 1 = fully open.
- `lc  in  1`: closed limit switch, 1 = fully closed.
- `ma  out  1`: open-motor command (registered).
- `mc  out  1`: close-motor command (registered).
- `state  out  3`: current state code (registered).
- `fault  out  1`: sticky fault flag (registered).

## Operation
- State codes: CLOSED=0, OPENING=1, OPEN_HOLD=2, CLOSING=3, DEAD=4, ESTOP=5, FAULT=6. Code 7 is unused and maps to FAULT.
- Outputs:
  - `ma`=1 only in OPENING; `mc`=1 only in CLOSING.
  - `fault`=1 only in FAULT.
  - `ma & mc` is never 1.
- One internal counter. It clears on every state entry and increments each cycle while in a timed state.
- Transition priority, evaluated every cycle:
  1. `la & lc` (sensor conflict) → FAULT, from any state.
  2. `se` → ESTOP, from any state except FAULT.
  3. The state-local rules below.
- CLOSED:
  - `sen` → OPENING.
  - If `la` is already 1, go to OPEN_HOLD instead.
- OPENING:
  - `la` → OPEN_HOLD.
  - Counter = TRAVEL_CYCLES-1 without `la` → FAULT.
- OPEN_HOLD:
  - Counter restarts at 0 every cycle `sen`=1.
  - Counter = HOLD_CYCLES-1 with `sen`=0 → CLOSING.
- CLOSING:
  - `lc` → CLOSED.
  - `sen` (obstruction) → DEAD, then OPENING.
  - Counter = TRAVEL_CYCLES-1 without `lc` → FAULT.
- DEAD:
  - Motors off for DEAD_CYCLES cycles, then → OPENING.
  - Exits to OPENING only; there is never a direct CLOSING→OPENING transition.
- ESTOP:
  - Motors off while `se`=1.
  - On the first cycle with `se`=0: `lc & ~sen` → CLOSED, `la` → OPEN_HOLD, otherwise → DEAD (the door reopens).
- FAULT: absorbing. Motors off, `fault`=1. Only `rst_n`=0 exits.
- `sen` during OPENING or OPEN_HOLD never reverses the door. In OPEN_HOLD it only extends the hold.

## Timing
- All inputs are sampled at the rising edge of `clk`. The state and all outputs update at that same edge.
- Input-to-output latency is 1 cycle. Example: `sen` high in cycle n (state CLOSED) gives `ma`=1 in cycle n+1.
- The counter is 0 in the first cycle of a timed state, so:
  - OPEN_HOLD lasts exactly HOLD_CYCLES cycles after the last `sen`=1 cycle.
  - DEAD lasts exactly DEAD_CYCLES cycles.
  - The timeout fires after TRAVEL_CYCLES motor cycles.
- Reset: while `rst_n`=0 at an edge, the next values are state=CLOSED, counter=0, `ma`=0, `mc`=0, `fault`=0. Reset overrides everything, including mid-travel and FAULT. Motors drop at that edge.
- On the first edge after reset releases, CLOSED rules apply. Limit switches are not trusted until then.
- Counter width is `$clog2` of the largest of the three parameters, plus 1. The counter saturates and never wraps.
- Simultaneous events in one cycle:
  - `la` and timeout in OPENING → OPEN_HOLD (limit wins).
  - `lc` and `sen` in CLOSING → CLOSED (limit wins). The next `sen` then triggers a fresh open from CLOSED.
  - `se` and a limit switch → ESTOP.

## Structure
- Shared package `door_pkg`: state code constants, the 3-bit state width, and the default timing constants. The existing door decode also uses this package for the status-pin map.
- Sub-module `door_timer`: clear/enable up-counter with saturation and a programmable terminal-count compare. It is shared by the hold, travel and dead-time checks through a compare-value mux driven by state.
- Top is the FSM plus the output registers only. No other hierarchy.

## Test plan
Bench parameters: HOLD_CYCLES=8, TRAVEL_CYCLES=20, DEAD_CYCLES=3.
- Normal cycle:
  - Stimulus: reset; pulse `sen` 1 cycle; `la` at cycle 10; `lc` 12 cycles after CLOSING entry.
  - Response: `ma`=1 for cycles 1–10; OPEN_HOLD for 8 cycles; `mc`=1 until `lc`; state returns to 0.
- Hold extension:
  - Stimulus: `sen` held 5 cycles inside OPEN_HOLD.
  - Response: CLOSING entry occurs exactly 8 cycles after `sen` falls.
- Obstruction reversal:
  - Stimulus: `sen` at CLOSING cycle 4.
  - Response: `mc`=0 next cycle; exactly 3 cycles with `ma`=`mc`=0 (state=4); then `ma`=1. `ma & mc` is never observed.
- Emergency stop:
  - Stimulus: `se` mid-OPENING for 6 cycles, with `la`=`lc`=0 on release.
  - Response: motors off within 1 cycle; state 5; then DEAD (3 cycles), then OPENING.
- Faults:
  - Stimulus A: withhold `la` for 20 OPENING cycles. Response: state 6, `fault`=1, sticky through `sen`/`se` activity.
  - Stimulus B: `la`=`lc`=1 in CLOSED. Response: FAULT next cycle.
- Reset mid-travel:
  - Stimulus: `rst_n`=0 for 1 cycle during CLOSING and during FAULT.
  - Response: next cycle shows state 0, `ma`=`mc`=`fault`=0, and the counter restarts from 0.
